// File: rtl/wb_pkg.sv
// Shared types and constants for the write-buffer drain controller.
// Entry layout: {tag[92:67], index[66:64], data[63:0]}.
package wb_pkg;

   localparam int TAG_W    = 26;
   localparam int IDX_W    = 3;
   localparam int DATA_W   = 64;
   localparam int BEAT_W   = 32;
   localparam int OFFSET_W = 3;
   localparam int CNT_W    = 16;

   localparam int IDX_LSB  = DATA_W;
   localparam int TAG_LSB  = DATA_W + IDX_W;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_CAPTURE,
      ST_BEAT0,
      ST_BEAT1
   } drain_state_t;

endpackage

// File: rtl/wb_sat_counter.sv
// Saturating up-counter with enable, clocked on the falling edge so it
// stays in step with the drain controller and the write buffer.
module wb_sat_counter #(
   parameter int WIDTH = 16
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             en,
   output logic [WIDTH-1:0] count
);

   always_ff @(negedge clk or negedge reset) begin
      if (!reset) begin
         count <= '0;
      end else if (en && (count != {WIDTH{1'b1}})) begin
         count <= count + WIDTH'(1);
      end
   end

endmodule

// File: rtl/wb_drain_ctrl.sv
// Pops the oldest write-buffer entry and emits it as two 32-bit memory write beats.
// Optional performance counters are built when WB_DRAIN_PERF_EN is defined.
module wb_drain_ctrl #(
   parameter int TAG_W  = wb_pkg::TAG_W,
   parameter int IDX_W  = wb_pkg::IDX_W,
   parameter int DATA_W = wb_pkg::DATA_W,
   parameter int BEAT_W = wb_pkg::BEAT_W
) (
   input  logic                                    clk,
   input  logic                                    reset,
   input  logic                                    buf_empty,
   input  logic [TAG_W+IDX_W+DATA_W-1:0]           buf_entry,
   output logic                                    buf_read,
   output logic                                    mem_req,
   output logic [TAG_W+IDX_W+wb_pkg::OFFSET_W-1:0] mem_addr,
   output logic [BEAT_W-1:0]                       mem_wdata,
   input  logic                                    mem_ack,
   output logic                                    busy
`ifdef WB_DRAIN_PERF_EN
   ,
   output logic [wb_pkg::CNT_W-1:0]                drain_count,
   output logic [wb_pkg::CNT_W-1:0]                stall_count
`endif
);
   import wb_pkg::*;

   localparam int ENTRY_W = TAG_W + IDX_W + DATA_W;

   drain_state_t       state;
   drain_state_t       state_nxt;
   logic [ENTRY_W-1:0] hold;
   logic               beat_hi;

   // NOTE: sequential state uses <= so every flop samples pre-edge values.
   always_ff @(negedge clk or negedge reset) begin
      if (!reset) begin
         state <= ST_IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // NOTE: the holding register is reset because mem_addr/mem_wdata decode
   // straight from it and must read zero while reset is active.
   always_ff @(negedge clk or negedge reset) begin
      if (!reset) begin
         hold <= '0;
      end else if (state == ST_CAPTURE) begin
         hold <= buf_entry;
      end
   end

   // NOTE: every output of this block gets a default first, so no latches.
   always_comb begin
      state_nxt = state;
      buf_read  = 1'b0;
      mem_req   = 1'b0;
      beat_hi   = 1'b0;
      case (state)
         ST_IDLE: begin
            if (!buf_empty) state_nxt = ST_CAPTURE;
         end
         ST_CAPTURE: begin
            buf_read  = 1'b1;
            state_nxt = ST_BEAT0;
         end
         ST_BEAT0: begin
            mem_req = 1'b1;
            if (mem_ack) state_nxt = ST_BEAT1;
         end
         ST_BEAT1: begin
            mem_req = 1'b1;
            beat_hi = 1'b1;
            if (mem_ack) state_nxt = ST_IDLE;
         end
         default: state_nxt = ST_IDLE;
      endcase
   end

   assign busy = (state != ST_IDLE);

   // Beats differ only in address bit 2; the block offset never carries into the index.
   assign mem_addr  = {hold[TAG_LSB +: TAG_W], hold[IDX_LSB +: IDX_W],
                       beat_hi, {(OFFSET_W-1){1'b0}}};
   assign mem_wdata = beat_hi ? hold[BEAT_W +: BEAT_W] : hold[0 +: BEAT_W];

`ifdef WB_DRAIN_PERF_EN
   logic drain_inc;
   logic stall_inc;

   assign drain_inc = (state == ST_BEAT1) && mem_ack;
   assign stall_inc = mem_req && !mem_ack;

   wb_sat_counter #(.WIDTH(CNT_W)) u_drain_cnt (
      .clk   (clk),
      .reset (reset),
      .en    (drain_inc),
      .count (drain_count)
   );

   wb_sat_counter #(.WIDTH(CNT_W)) u_stall_cnt (
      .clk   (clk),
      .reset (reset),
      .en    (stall_inc),
      .count (stall_count)
   );
`endif

endmodule

// File: doc/wb_drain_ctrl.md
# wb_drain_ctrl

Drain controller sitting directly downstream of the cache write buffer. It pops the oldest 93-bit entry (tag, index, 64-bit block) whenever the buffer is non-empty. It converts the entry into two 32-bit memory write beats over a req/ack handshake. It holds each beat stable until memory accepts it, so the buffer drains in FIFO order with no loss.

## Interface
Parameters:
- TAG_W, 26, tag field width (entry bits [92:67])
- IDX_W, 3, index field width (entry bits [66:64])
- DATA_W, 64, data block width (entry bits [63:0])
- BEAT_W, 32, memory write data width per beat

Ports:
- clk  in  1  single clock; all state updates on negedge clk, matching the write buffer
- reset  in  1  asynchronous, active-low; 0 clears all state immediately
- buf_empty  in  1  write buffer holds no valid entry
- buf_entry  in  93  head entry of write buffer, valid while buf_empty=0
- buf_read  out  1  one-cycle pop pulse to write buffer
- mem_req  out  1  write beat request
- mem_addr  out  32  byte address of current beat
- mem_wdata  out  32  data of current beat
- mem_ack  in  1  memory accepted current beat (sampled only while mem_req=1)
- busy  out  1  FSM not in IDLE

## Operation
- FSM states: IDLE, CAPTURE, BEAT0, BEAT1.
- IDLE: if buf_empty=0 -> CAPTURE; else stay.
- CAPTURE: latch buf_entry into holding register; buf_read=1 for exactly this cycle; -> BEAT0.
- BEAT0: mem_req=1, mem_addr={tag,index,3'b000}, mem_wdata=data[31:0]; on mem_ack=1 -> BEAT1, else hold.
- BEAT1: mem_req=1, mem_addr={tag,index,3'b100}, mem_wdata=data[63:32]; on mem_ack=1 -> IDLE, else hold.
- Address arithmetic: 26+3+3 = 32 bits, no carry; beat 1 address differs from beat 0 only in bit 2.
- mem_addr/mem_wdata are driven from the holding register, so they are stable for the whole request regardless of buf_entry changes.
- mem_ack while mem_req=0 is ignored.
- busy=1 in CAPTURE, BEAT0 and BEAT1.
- Reset values: state=IDLE, buf_read=0, mem_req=0, mem_addr=0, mem_wdata=0, busy=0, holding register=0.

## Timing
- buf_empty falling while in IDLE: CAPTURE next cycle, mem_req=1 at cycle 2.
- Minimum per entry is 3 cycles (CAPTURE, BEAT0, BEAT1) with mem_ack tied high.
- Back-to-back entries: IDLE is revisited for one cycle between entries, so the sustained rate is 4 cycles per entry.
- A one-cycle ack advances exactly one beat. Ack held high advances one beat per cycle.
- buf_read never asserts for two consecutive cycles.
- buf_read is never asserted while buf_empty=1.
- Reset asserted mid-beat: mem_req drops asynchronously and the in-flight entry is discarded. The write buffer shares the reset, so no stale pop occurs.
- Reset released: first evaluation occurs on the next negedge clk.

## Configuration
- WB_DRAIN_PERF_EN defined: adds two output ports.
  - drain_count  out  16: entries completed, incremented on BEAT1 ack.
  - stall_count  out  16: cycles with mem_req=1 and mem_ack=0.
  - Both counters saturate at 16'hFFFF and reset to 0.
- Undefined: the ports and counters are absent; all other behaviour is identical.

## Structure
- Shared package wb_pkg:
  - TAG_W, IDX_W, DATA_W, BEAT_W
  - entry field offsets (TAG_LSB=67, IDX_LSB=64)
  - OFFSET_W=3
  - drain state enum
- One sub-module: wb_sat_counter (16-bit saturating increment with enable), instantiated twice under WB_DRAIN_PERF_EN.

## Test plan
- Single entry, tag=26'h2AAAAAA, index=3'd5, data=64'h1122334455667788, mem_ack tied 1:
  - beat 0: addr=32'hAAAAAAA8, wdata=32'h55667788
  - beat 1: addr=32'hAAAAAAAC, wdata=32'h11223344
  - exactly one buf_read pulse
- Ack delayed 5 cycles on each beat: mem_req, mem_addr and mem_wdata are held stable throughout; buf_entry changes during the wait are not reflected on the outputs.
- Three queued entries, ack tied high:
  - 6 beats issued in FIFO order
  - 3 buf_read pulses spaced 4 cycles apart
  - busy falls after the last beat
- Reset pulled low during BEAT1: mem_req=0, busy=0 and mem_addr=0 immediately. After release with buf_empty=1, the block stays IDLE.
- Spurious mem_ack=1 while IDLE with buf_empty=1: no state change, no buf_read.
- WB_DRAIN_PERF_EN: 2 entries with 3 stall cycles in total -> drain_count=2, stall_count=3. Forced saturation holds the counter at 16'hFFFF.
